// File: rtl/div.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, MSB first.
// Optional DIV_UNSIGNED_EN adds a sem_sinal input selecting unsigned operation.
module div #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ini,
`ifdef DIV_UNSIGNED_EN
   input  logic          sem_sinal,
`endif
   input  logic [DW-1:0] A,
   input  logic [VW-1:0] B,
   output logic [DW-1:0] quociente,
   output logic [VW-1:0] resto,
   output logic          pronto,
   output logic          ocupado,
   output logic          div_zero
);

   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] a_q, a_d;      // |A| shifting out, quotient bits shifting in
   logic [VW-1:0] b_q, b_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          sa_q, sa_d, sb_q, sb_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [VW-1:0] res_q, res_d;
   logic          pronto_q, pronto_d, dz_q, dz_d;

   logic          uns, sa_in, sb_in, qbit;
   logic [VW:0]   rem_sh;

`ifdef DIV_UNSIGNED_EN
   assign uns = sem_sinal;
`else
   assign uns = 1'b0;
`endif

   assign sa_in = A[DW-1] & ~uns;
   assign sb_in = B[VW-1] & ~uns;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      quo_d    = quo_q;
      res_d    = res_q;
      pronto_d = 1'b0;
      dz_d     = dz_q;
      // Remainder stays below |B|, so one extra bit holds the shifted value.
      rem_sh   = {rem_q, a_q[DW-1]};
      qbit     = (rem_sh >= {1'b0, b_q});
      case (state_q)
         IDLE: begin
            if (ini) begin
               if (B == '0) begin
                  quo_d    = '1;
                  res_d    = A[VW-1:0];
                  dz_d     = 1'b1;
                  pronto_d = 1'b1;
               end else begin
                  a_d     = sa_in ? -A : A;
                  b_d     = sb_in ? -B : B;
                  sa_d    = sa_in;
                  sb_d    = sb_in;
                  rem_d   = '0;
                  cnt_d   = CW'(DW - 1);
                  dz_d    = 1'b0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = qbit ? VW'(rem_sh - {1'b0, b_q}) : VW'(rem_sh);
            a_d   = {a_q[DW-2:0], qbit};
            if (cnt_q == '0) state_d = FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         FIX: begin
            quo_d    = (sa_q ^ sb_q) ? -a_q : a_q;
            res_d    = sa_q ? -rem_q : rem_q;
            pronto_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         quo_q    <= '0;
         res_q    <= '0;
         pronto_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         quo_q    <= quo_d;
         res_q    <= res_d;
         pronto_q <= pronto_d;
         dz_q     <= dz_d;
      end
   end

   assign quociente = quo_q;
   assign resto     = res_q;
   assign pronto    = pronto_q;
   assign div_zero  = dz_q;
   assign ocupado   = (state_q != IDLE);

endmodule

// File: tb/tb_div.sv
// Randomized self-checking bench for div against a plain-arithmetic model.
module tb_div;
   logic        clk = 1'b0;
   logic        rst, ini;
   logic [31:0] A;
   logic [15:0] B;
`ifdef DIV_UNSIGNED_EN
   logic        sem_sinal;
`endif
   logic [31:0] quociente;
   logic [15:0] resto;
   logic        pronto, ocupado, div_zero;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div dut (
      .clk(clk), .rst(rst), .ini(ini),
`ifdef DIV_UNSIGNED_EN
      .sem_sinal(sem_sinal),
`endif
      .A(A), .B(B), .quociente(quociente), .resto(resto),
      .pronto(pronto), .ocupado(ocupado), .div_zero(div_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [15:0] b, input bit uns,
                                 output logic [31:0] q, output logic [15:0] r);
      longint la, lb;
      if (b == 16'd0) begin
         q = 32'hFFFF_FFFF;
         r = a[15:0];
      end else begin
         if (uns) begin
            la = longint'({32'd0, a});
            lb = longint'({48'd0, b});
         end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
         end
         // longint division truncates toward zero; remainder follows dividend
         q = 32'(la / lb);
         r = 16'(la % lb);
      end
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [15:0] b, input bit uns, input bit poke);
      logic [31:0] eq;
      logic [15:0] er;
      int cyc, busy;
      bit  dz;
      model(a, b, uns, eq, er);
      dz = (b == 16'd0);
      @(negedge clk);
      A = a; B = b; ini = 1'b1;
`ifdef DIV_UNSIGNED_EN
      sem_sinal = uns;
`endif
      @(posedge clk);
      @(negedge clk);
      ini = 1'b0;
      cyc = 0; busy = 0;
      while (!pronto && cyc < 60) begin
         if (ocupado) busy++;
         A = $urandom; B = 16'($urandom);
         if (poke && cyc == 10) begin
            A = 32'd5; B = 16'd1; ini = 1'b1;
         end else ini = 1'b0;
         @(negedge clk);
         cyc++;
      end
      ini = 1'b0;
      chk("latency", 64'(cyc), dz ? 64'd0 : 64'd33);
      chk("busy_cycles", 64'(busy), dz ? 64'd0 : 64'd33);
      chk("quociente", 64'(quociente), 64'(eq));
      chk("resto", 64'(resto), 64'(er));
      chk("div_zero", 64'(div_zero), 64'(dz));
      chk("ocupado_at_pronto", 64'(ocupado), 64'd0);
      @(negedge clk);
      chk("pronto_pulse", 64'(pronto), 64'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [15:0] rb;
      rst = 1'b1; ini = 1'b0; A = '0; B = '0;
`ifdef DIV_UNSIGNED_EN
      sem_sinal = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_quo", 64'(quociente), 64'd0);
      chk("rst_res", 64'(resto), 64'd0);
      chk("rst_flags", 64'({pronto, ocupado, div_zero}), 64'd0);
      rst = 1'b0;

      run_op(32'd100, 16'd7, 1'b0, 1'b0);
      run_op(32'hFFFF_FF9C, 16'd7, 1'b0, 1'b0);
      run_op(32'd100, 16'hFFF9, 1'b0, 1'b0);
      run_op(32'hFFFF_FF9C, 16'hFFF9, 1'b0, 1'b0);
      run_op(32'h0000_1234, 16'd0, 1'b0, 1'b0);
      run_op(32'h8000_0000, 16'hFFFF, 1'b0, 1'b1);
      run_op(32'h8000_0000, 16'h8000, 1'b0, 1'b0);
      run_op(32'h7FFF_FFFF, 16'h8000, 1'b0, 1'b0);

      // reset in the middle of an operation
      @(negedge clk);
      A = 32'd1000; B = 16'd3; ini = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ini = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_quo", 64'(quociente), 64'd0);
      chk("midrst_res", 64'(resto), 64'd0);
      chk("midrst_ocupado", 64'(ocupado), 64'd0);
      repeat (2) begin
         @(negedge clk);
         chk("midrst_pronto", 64'(pronto), 64'd0);
      end
      rst = 1'b0;
      run_op(32'd1000, 16'd3, 1'b0, 1'b0);

`ifdef DIV_UNSIGNED_EN
      run_op(32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0);
      run_op(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 16'($urandom_range(1, 20));
            1:       rb = 16'd0;
            2:       rb = 16'h8000;
            default: rb = 16'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
`ifdef DIV_UNSIGNED_EN
         run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
         run_op(ra, rb, 1'b0, 1'($urandom_range(0, 1)));
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
